// File: rtl/nn_pkg.sv
//------------------------------------------------------------------------------
// Module   : nn_pkg
// Purpose  : Shared types, defaults and helpers for the neural-network datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

   localparam int NN_ADDR_W = 8;

   typedef enum logic [1:0] {
      AG_IDLE = 2'd0,
      AG_RUN  = 2'd1,
      AG_BIAS = 2'd2,
      AG_DONE = 2'd3
   } ag_state_t;

   // Bits needed to hold 0..value-1; never less than one bit.
   function automatic int clog2w(input int value);
      int w;
      w = 1;
      while ((w < 31) && ((1 << w) < value))
         w = w + 1;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/address_generator_wrap_counter.sv
//------------------------------------------------------------------------------
// Module   : wrap_counter
// Purpose  : Modulo-MODULUS up-counter with synchronous clear and wrap pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wrap_counter
   import nn_pkg::*;
#(
   parameter int MODULUS = 4,
   parameter int WIDTH   = clog2w(MODULUS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_count <= '0;
      else if (clear)
         r_count <= '0;
      else if (enable)
         r_count <= (r_count == C_LAST) ? '0 : r_count + WIDTH'(1);
   end

   // Pulses on the enabled step that returns the count to zero.
   assign wrap  = enable && !clear && (r_count == C_LAST);
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/address_generator.sv
//------------------------------------------------------------------------------
// Module   : address_generator
// Purpose  : Walks every (neuron, input) pair of a layer and issues registered
//            input/weight read addresses. Macro BIAS_FETCH_EN adds a bias fetch
//            after each neuron's last input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module address_generator
   import nn_pkg::*;
#(
   parameter int N_INPUTS    = 4,
   parameter int N_NEURONS   = 3,
   parameter int ADDR_W      = NN_ADDR_W,
   parameter int INPUT_BASE  = 0,
   parameter int WEIGHT_BASE = 0,
   parameter int BIAS_BASE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ag_rst,
   input  logic              ag_read,
   output logic [ADDR_W-1:0] input_addr,
   output logic [ADDR_W-1:0] weight_addr,
   output logic              addr_valid,
   output logic              last_input,
   output logic [ADDR_W-1:0] neuron_idx,
   output logic [ADDR_W-1:0] bias_addr,
   output logic              bias_valid,
   output logic              done
);

   localparam int C_IN_W  = clog2w(N_INPUTS);
   localparam int C_NRN_W = clog2w(N_NEURONS);

   if ((N_INPUTS < 1) || (N_NEURONS < 1) || (ADDR_W < 1) || (ADDR_W > 32) ||
       (INPUT_BASE < 0) || (WEIGHT_BASE < 0) || (BIAS_BASE < 0) ||
       ((longint'(N_NEURONS) * longint'(N_INPUTS) + longint'(WEIGHT_BASE)) >
        (longint'(1) << ADDR_W))) begin : g_param_error
      $error("address_generator: illegal parameter combination");
   end

   ag_state_t r_state;
   ag_state_t w_state_next;

   logic [C_IN_W-1:0]  w_in_cnt;
   logic [C_NRN_W-1:0] w_nrn_cnt;
   logic [ADDR_W-1:0]  r_weight_cnt;
   logic               w_in_wrap;
   logic               w_nrn_wrap;
   logic               w_nrn_enable;
   logic               w_issue;

   logic [ADDR_W-1:0]  r_input_addr;
   logic [ADDR_W-1:0]  r_weight_addr;
   logic [ADDR_W-1:0]  r_neuron_idx;
   logic               r_addr_valid;
   logic               r_last_input;
   logic               r_done;

   assign w_issue = !ag_rst && ag_read && ((r_state == AG_IDLE) || (r_state == AG_RUN));

`ifdef BIAS_FETCH_EN
   logic w_bias_issue;
   assign w_bias_issue = !ag_rst && ag_read && (r_state == AG_BIAS);
   // The neuron index stays on the finished neuron until its bias is fetched.
   assign w_nrn_enable = w_bias_issue;
`else
   assign w_nrn_enable = w_in_wrap;
`endif

   wrap_counter #(
      .MODULUS (N_INPUTS),
      .WIDTH   (C_IN_W)
   ) u_input_cnt (
      .clk     (clk),
      .reset   (reset),
      .enable  (w_issue),
      .clear   (ag_rst),
      .count   (w_in_cnt),
      .wrap    (w_in_wrap)
   );

   wrap_counter #(
      .MODULUS (N_NEURONS),
      .WIDTH   (C_NRN_W)
   ) u_neuron_cnt (
      .clk     (clk),
      .reset   (reset),
      .enable  (w_nrn_enable),
      .clear   (ag_rst),
      .count   (w_nrn_cnt),
      .wrap    (w_nrn_wrap)
   );

   // Row-major weights make the weight address a running count of issued pairs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_weight_cnt <= '0;
      else if (ag_rst)
         r_weight_cnt <= '0;
      else if (w_issue)
         r_weight_cnt <= r_weight_cnt + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= AG_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (ag_rst) begin
         w_state_next = AG_IDLE;
      end else begin
         case (r_state)
            AG_IDLE, AG_RUN: begin
               if (ag_read) begin
`ifdef BIAS_FETCH_EN
                  w_state_next = w_in_wrap ? AG_BIAS : AG_RUN;
`else
                  w_state_next = w_nrn_wrap ? AG_DONE : AG_RUN;
`endif
               end
            end
            AG_BIAS: begin
`ifdef BIAS_FETCH_EN
               if (ag_read)
                  w_state_next = w_nrn_wrap ? AG_DONE : AG_RUN;
`else
               w_state_next = AG_IDLE;
`endif
            end
            AG_DONE: w_state_next = AG_DONE;
            default: w_state_next = AG_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_input_addr  <= '0;
         r_weight_addr <= '0;
         r_neuron_idx  <= '0;
         r_addr_valid  <= 1'b0;
         r_last_input  <= 1'b0;
         r_done        <= 1'b0;
      end else if (ag_rst) begin
         r_input_addr  <= '0;
         r_weight_addr <= '0;
         r_neuron_idx  <= '0;
         r_addr_valid  <= 1'b0;
         r_last_input  <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_addr_valid <= w_issue;
         r_last_input <= w_in_wrap;
         r_done       <= (r_state == AG_DONE);
         if (w_issue) begin
            r_input_addr  <= ADDR_W'(INPUT_BASE) + ADDR_W'(w_in_cnt);
            r_weight_addr <= ADDR_W'(WEIGHT_BASE) + r_weight_cnt;
            r_neuron_idx  <= ADDR_W'(w_nrn_cnt);
         end
      end
   end

`ifdef BIAS_FETCH_EN
   logic [ADDR_W-1:0] r_bias_addr;
   logic              r_bias_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bias_addr  <= '0;
         r_bias_valid <= 1'b0;
      end else if (ag_rst) begin
         r_bias_addr  <= '0;
         r_bias_valid <= 1'b0;
      end else begin
         r_bias_valid <= w_bias_issue;
         if (w_bias_issue)
            r_bias_addr <= ADDR_W'(BIAS_BASE) + ADDR_W'(w_nrn_cnt);
      end
   end

   assign bias_addr  = r_bias_addr;
   assign bias_valid = r_bias_valid;
`else
   assign bias_addr  = '0;
   assign bias_valid = 1'b0;
`endif

   assign input_addr  = r_input_addr;
   assign weight_addr = r_weight_addr;
   assign neuron_idx  = r_neuron_idx;
   assign addr_valid  = r_addr_valid;
   assign last_input  = r_last_input;
   assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_address_generator.sv
//------------------------------------------------------------------------------
// Module   : tb_address_generator
// Purpose  : Self-checking bench for address_generator (pair-index model plus
//            directed literal checks). Honours BIAS_FETCH_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_address_generator;

`ifdef BIAS_FETCH_EN
   localparam int NI = 2;
   localparam int NN = 2;
   localparam int BB = 16;
   localparam bit BIAS_ON = 1'b1;
`else
   localparam int NI = 4;
   localparam int NN = 3;
   localparam int BB = 0;
   localparam bit BIAS_ON = 1'b0;
`endif
   localparam int IB = 0;
   localparam int WB = 0;
   localparam int TOTAL = NI * NN;

   logic       clk = 1'b0;
   logic       reset;
   logic       ag_rst;
   logic       ag_read;
   logic [7:0] input_addr;
   logic [7:0] weight_addr;
   logic       addr_valid;
   logic       last_input;
   logic [7:0] neuron_idx;
   logic [7:0] bias_addr;
   logic       bias_valid;
   logic       done;

   int n_vec = 0;
   int n_err = 0;
   bit en_cmp = 1'b0;

   address_generator #(
      .N_INPUTS    (NI),
      .N_NEURONS   (NN),
      .ADDR_W      (8),
      .INPUT_BASE  (IB),
      .WEIGHT_BASE (WB),
      .BIAS_BASE   (BB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ag_rst      (ag_rst),
      .ag_read     (ag_read),
      .input_addr  (input_addr),
      .weight_addr (weight_addr),
      .addr_valid  (addr_valid),
      .last_input  (last_input),
      .neuron_idx  (neuron_idx),
      .bias_addr   (bias_addr),
      .bias_valid  (bias_valid),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   // Model: the layer is a flat list of TOTAL pairs; pair p belongs to neuron
   // p/NI, input p%NI, weight row-major offset p.
   int         m_next = 0;
   int         m_p = 0;
   bit         m_bias_due = 1'b0;
   bit         m_fin = 1'b0;
   logic [7:0] e_in = '0, e_w = '0, e_n = '0, e_b = '0;
   bit         e_av = 1'b0, e_last = 1'b0, e_bv = 1'b0, e_done = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset || ag_rst) begin
         m_next = 0; m_bias_due = 1'b0; m_fin = 1'b0;
         e_in = '0; e_w = '0; e_n = '0; e_b = '0;
         e_av = 1'b0; e_last = 1'b0; e_bv = 1'b0; e_done = 1'b0;
      end else begin
         e_done = m_fin;
         e_av = 1'b0; e_last = 1'b0; e_bv = 1'b0;
         if (!m_fin && ag_read) begin
            if (m_bias_due) begin
               e_bv = 1'b1;
               e_b = 8'(BB + (m_next - 1) / NI);
               m_bias_due = 1'b0;
               if (m_next == TOTAL) m_fin = 1'b1;
            end else begin
               m_p = m_next;
               e_av = 1'b1;
               e_in = 8'(IB + m_p % NI);
               e_w = 8'(WB + m_p);
               e_n = 8'(m_p / NI);
               e_last = (m_p % NI) == (NI - 1);
               m_next = m_next + 1;
               if (e_last && BIAS_ON) m_bias_due = 1'b1;
               else if (m_next == TOTAL) m_fin = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en_cmp) begin
         chk("m_addr_valid", addr_valid, e_av);
         chk("m_last_input", last_input, e_last);
         chk("m_input_addr", input_addr, e_in);
         chk("m_weight_addr", weight_addr, e_w);
         chk("m_neuron_idx", neuron_idx, e_n);
         chk("m_bias_valid", bias_valid, e_bv);
         chk("m_bias_addr", bias_addr, e_b);
         chk("m_done", done, e_done);
      end
   end

   initial begin
      reset = 1'b0; ag_rst = 1'b0; ag_read = 1'b0;
      step; step;
      en_cmp = 1'b1;
      reset = 1'b1;
      step;
      chk("idle_valid", addr_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_weight", weight_addr, 0);
`ifndef BIAS_FETCH_EN
      // Async reset mid-run clears outputs without a clock edge.
      ag_read = 1'b1;
      repeat (5) step;
      chk("pre_reset_weight", weight_addr, 4);
      reset = 1'b0;
      #1;
      chk("async_valid", addr_valid, 0);
      chk("async_weight", weight_addr, 0);
      chk("async_input", input_addr, 0);
      chk("async_neuron", neuron_idx, 0);
      chk("async_last", last_input, 0);
      ag_read = 1'b0;
      reset = 1'b1;
      step;
      // Full sweep.
      ag_read = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step;
         chk("sweep_valid", addr_valid, 1);
         chk("sweep_weight", weight_addr, i);
         chk("sweep_input", input_addr, i % 4);
         chk("sweep_neuron", neuron_idx, i / 4);
         chk("sweep_last", last_input, (i % 4) == 3);
         chk("sweep_done", done, 0);
      end
      step;
      chk("done_set", done, 1);
      chk("done_valid", addr_valid, 0);
      repeat (9) begin
         step;
         chk("done_hold", done, 1);
         chk("done_hold_valid", addr_valid, 0);
      end
      ag_rst = 1'b1;
      step;
      chk("restart_done", done, 0);
      ag_rst = 1'b0;
      step;
      chk("fresh_weight", weight_addr, 0);
      chk("fresh_valid", addr_valid, 1);
      // Pause: 0,1,0,1.
      ag_read = 1'b0; step; chk("pause_valid", addr_valid, 0);
      ag_read = 1'b1; step; chk("pause_w1", weight_addr, 1);
      ag_read = 1'b0; step; chk("pause_valid2", addr_valid, 0);
      ag_read = 1'b1; step; chk("pause_w2", weight_addr, 2);
      step; step; step;
      chk("mid_w5", weight_addr, 5);
      // Restart mid-layer with ag_read held high.
      ag_rst = 1'b1;
      step;
      chk("mid_rst_valid", addr_valid, 0);
      chk("mid_rst_done", done, 0);
      ag_rst = 1'b0;
      step;
      chk("mid_rst_weight", weight_addr, 0);
      chk("mid_rst_input", input_addr, 0);
      chk("mid_rst_valid2", addr_valid, 1);
      step; step;
      chk("simul_pre_w2", weight_addr, 2);
      // Both strobes high: restart wins.
      ag_rst = 1'b1;
      step;
      chk("simul_valid", addr_valid, 0);
      chk("simul_weight", weight_addr, 0);
      ag_rst = 1'b0;
      step;
      chk("simul_next_weight", weight_addr, 0);
      chk("simul_next_valid", addr_valid, 1);
`else
      ag_read = 1'b1;
      step; chk("b_w0", weight_addr, 0); chk("b_v0", addr_valid, 1); chk("b_l0", last_input, 0);
      step; chk("b_w1", weight_addr, 1); chk("b_l1", last_input, 1);
      step; chk("b_bv16", bias_valid, 1); chk("b_ba16", bias_addr, 16); chk("b_av16", addr_valid, 0);
      step; chk("b_w2", weight_addr, 2); chk("b_n2", neuron_idx, 1); chk("b_bv_off", bias_valid, 0);
      step; chk("b_w3", weight_addr, 3); chk("b_l3", last_input, 1);
      step; chk("b_bv17", bias_valid, 1); chk("b_ba17", bias_addr, 17); chk("b_done_early", done, 0);
      step; chk("b_done", done, 1); chk("b_done_valid", addr_valid, 0); chk("b_done_bv", bias_valid, 0);
      repeat (3) begin step; chk("b_done_hold", done, 1); end
      ag_rst = 1'b1;
      step;
      chk("b_restart_done", done, 0);
      ag_rst = 1'b0;
`endif
      // Model-checked run with a fixed read pattern to completion.
      for (int i = 0; i < 40; i++) begin
         ag_read = (i % 3) != 0;
         step;
      end
      chk("final_done", done, 1);
      en_cmp = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/address_generator.md
Name: address_generator

Overview:
- Consumer end of the control unit's AG_rst/AG_read strobes.
- Walks every (neuron, input) pair of one layer and issues registered read addresses to the input and weight memories.
- Flags the last input of each neuron to the ALU (dot-product boundary) and flags layer completion.
- Sits between the control unit and the input/weight RAMs of the neural-network datapath.

Parameters:
N_INPUTS, 4, inputs per neuron (>=1)
N_NEURONS, 3, neurons per layer (>=1)
ADDR_W, 8, memory address width; N_NEURONS*N_INPUTS + WEIGHT_BASE must be <= 2**ADDR_W
INPUT_BASE, 0, base address of the input vector
WEIGHT_BASE, 0, base address of the row-major weight matrix (neuron-major)
BIAS_BASE, 0, base address of the bias vector (used only with BIAS_FETCH_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ag_rst  input  1  synchronous restart strobe from the control unit, active-high
ag_read  input  1  advance enable; one address pair issued per cycle while high
input_addr  output  ADDR_W  INPUT_BASE + current input index
weight_addr  output  ADDR_W  WEIGHT_BASE + neuron*N_INPUTS + input index
addr_valid  output  1  input_addr/weight_addr valid this cycle
last_input  output  1  qualifies addr_valid; the issued pair is the neuron's final input
neuron_idx  output  ADDR_W  neuron index of the issued pair
bias_addr  output  ADDR_W  BIAS_BASE + neuron index (feature only, else 0)
bias_valid  output  1  bias_addr valid (feature only, else 0)
done  output  1  whole layer issued; held until restart

Behaviour:
- States: IDLE, RUN, BIAS (feature only), DONE.
- reset low (async): state IDLE; input counter, neuron counter and weight counter = 0; every output = 0.
- ag_rst high at a clock edge: same values as async reset. It has priority over ag_read in every state, including mid-layer and in DONE.
- IDLE: ag_read=1 -> RUN and issue pair (0,0) at that edge. ag_read=0 -> stay IDLE, addr_valid=0.
- Latency: outputs are registered. A pair issued at edge k is visible with addr_valid=1 in the cycle after edge k, i.e. one cycle after ag_read is sampled high.
- RUN with ag_read=1:
  - register input_addr, weight_addr and neuron_idx from the counters; addr_valid=1.
  - last_input=1 iff input counter == N_INPUTS-1.
  - Then advance: input counter wraps N_INPUTS-1 -> 0 and increments the neuron counter; weight counter increments by 1 (no multiplier).
- RUN with ag_read=0: counters hold, addr_valid=0, last_input=0. This is a pause, not a restart.
- Pair (N_NEURONS-1, N_INPUTS-1) issued: next state DONE (or BIAS when the feature is on); done=1 from the following cycle.
- DONE: ag_read ignored; addr_valid=0; done stays 1 until ag_rst or reset.
- N_INPUTS=1: every issued pair has last_input=1.
- Address arithmetic is modulo 2**ADDR_W. Parameter violations are caught by an elaboration-time check, not handled at runtime.
- ag_rst and ag_read both high: restart wins; nothing is issued that cycle.

Optional Feature:
- Macro: BIAS_FETCH_EN.
- Defined:
  - After issuing each neuron's last pair with ag_read=1, the next ag_read=1 cycle enters BIAS.
  - BIAS issues bias_addr = BIAS_BASE + neuron with bias_valid=1 and addr_valid=0, then returns to RUN for the next neuron.
  - After the final neuron's bias, the block goes to DONE.
  - ag_read=0 in BIAS holds the state.
- Undefined: BIAS state absent; bias_addr and bias_valid are tied to 0.

Decomposition:
- Shared package nn_pkg:
  - state encoding constants (AG_IDLE, AG_RUN, AG_BIAS, AG_DONE);
  - default ADDR_W;
  - a clog2-style width function.
- One natural sub-module, wrap_counter:
  - parameterised modulus;
  - inputs enable and clear;
  - outputs count and wrap pulse.
- It is instantiated for the input index and for the neuron index; the weight counter is a plain incrementer.

Test Plan:
1. Reset and restart: reset low mid-run -> all outputs 0 immediately. Release, then ag_read=1 for 12 cycles (defaults) -> weight_addr 0..11, input_addr 0,1,2,3 repeating, neuron_idx 0,0,0,0,1,...,2, last_input on weight_addr 3, 7 and 11, done=1 one cycle after the pair with weight_addr=11.
2. Pause: ag_read toggled 1,0,1,0 -> addresses advance only on high cycles; no gaps in the sequence and no repeats.
3. Restart mid-layer: ag_rst after weight_addr=5, with ag_read held 1 -> next valid pair is (0,0); done=0.
4. DONE hold: after completion keep ag_read=1 for 10 cycles -> addr_valid=0, done=1 throughout. Then ag_rst -> done=0 and a fresh sweep from 0.
5. Simultaneous strobes: ag_rst=ag_read=1 in RUN -> no pair issued that cycle; counters=0.
6. BIAS_FETCH_EN, N_INPUTS=2, N_NEURONS=2, BIAS_BASE=16:
   - sequence is w0, w1(last), bias 16, w2, w3(last), bias 17, then done=1;
   - the bias cycles show bias_valid=1 and addr_valid=0.
